// File: rtl/mod_n_counter_fsm.sv
// Runtime-programmable modulo-N up/down counter with IDLE/RUN/DONE control FSM.
// Optional MOD_N_GRAY_OUT_EN adds a registered Gray-coded copy of q (q_gray).
module mod_n_counter_fsm #(
  parameter int WIDTH       = 8,
  parameter int MOD_DEFAULT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             busy,
  output logic             done
`ifdef MOD_N_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH:0]   MOD_RST = MOD_DEFAULT[WIDTH:0];
  localparam logic [WIDTH:0]   M_ONE   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] Q_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0] mod_q, mod_d;
  logic           os_q, os_d;
  logic           wrap_q, wrap_d;

  logic [WIDTH:0]   mod_new;
  logic [WIDTH:0]   mod_m1;
  logic [WIDTH-1:0] q_init;
  logic             at_top;
  logic             at_bot;
  logic             do_start;
  logic             do_count;

  // mod_val of 0 selects the full 2^WIDTH range
  assign mod_new = (mod_val == '0) ? {1'b1, {WIDTH{1'b0}}}
                                   : {1'b0, mod_val};
  assign mod_m1  = mod_q - M_ONE;
  assign q_init  = up_dn ? '0 : (mod_val - Q_ONE);
  assign at_top  = ({1'b0, q_q} == mod_m1);
  assign at_bot  = (q_q == '0);

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign tc   = busy && (up_dn ? at_top : at_bot);
  assign q    = q_q;
  assign wrap = wrap_q;

  always_comb begin
    state_d  = state_q;
    mod_d    = mod_q;
    os_d     = os_q;
    do_start = 1'b0;
    do_count = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          mod_d    = mod_new;
          os_d     = oneshot;
          do_start = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (en) begin
          if (tc && os_q) begin
            if (!load) state_d = S_DONE;
          end else begin
            do_count = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // load clamps against the modulus in effect after this edge
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = ({1'b0, load_val} < mod_d) ? load_val : '0;
    end else if (do_start) begin
      q_d = q_init;
    end else if (do_count) begin
      if (up_dn) begin
        q_d    = at_top ? '0 : (q_q + Q_ONE);
        wrap_d = at_top;
      end else begin
        q_d    = at_bot ? mod_m1[WIDTH-1:0] : (q_q - Q_ONE);
        wrap_d = at_bot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      mod_q   <= MOD_RST;
      os_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mod_q   <= mod_d;
      os_q    <= os_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef MOD_N_GRAY_OUT_EN
  logic [WIDTH-1:0] q_gray_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_gray_q <= '0;
    end else begin
      q_gray_q <= q_d ^ (q_d >> 1);
    end
  end

  assign q_gray = q_gray_q;
`endif

endmodule

// File: tb/tb_mod_n_counter_fsm.sv
// Bench for mod_n_counter_fsm: directed vector table, hand sequences,
// and randomized traffic against an arithmetic reference model.
module tb_mod_n_counter_fsm;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start, stop, en, up_dn, oneshot, load;
  logic [W-1:0] mod_val, load_val;
  logic [W-1:0] q;
  logic         tc, wrap, busy, done;
`ifdef MOD_N_GRAY_OUT_EN
  logic [W-1:0] q_gray;
`endif

  mod_n_counter_fsm #(.WIDTH(W), .MOD_DEFAULT(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .up_dn    (up_dn),
    .oneshot  (oneshot),
    .mod_val  (mod_val),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .busy     (busy),
    .done     (done)
`ifdef MOD_N_GRAY_OUT_EN
    ,
    .q_gray   (q_gray)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit st, sp, e, u, os, ld;
    int mv, lv;
    int xq;
    bit xtc, xwrap, xbusy, xdone;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit st, sp, e, u, os, ld, input int mv, lv,
                     input int xq, input bit xtc, xwrap, xbusy, xdone);
    vec_t v;
    v.st = st; v.sp = sp; v.e = e; v.u = u; v.os = os; v.ld = ld;
    v.mv = mv; v.lv = lv; v.xq = xq;
    v.xtc = xtc; v.xwrap = xwrap; v.xbusy = xbusy; v.xdone = xdone;
    vq.push_back(v);
  endtask

  task automatic drive(input bit st, sp, e, u, os, ld, input int mv, lv);
    start = st; stop = sp; en = e; up_dn = u; oneshot = os; load = ld;
    mod_val = mv[W-1:0]; load_val = lv[W-1:0];
  endtask

  // reference model: state 0=idle 1=run 2=done
  int m_st, m_q, m_mod;
  bit m_os, m_wrap;

  task automatic m_reset();
    m_st = 0; m_q = 0; m_mod = 5; m_os = 0; m_wrap = 0;
  endtask

  function automatic bit m_tc();
    if (m_st != 1) return 1'b0;
    return up_dn ? (m_q == m_mod - 1) : (m_q == 0);
  endfunction

  task automatic m_step();
    int n_st, n_q, n_mod;
    bit n_os, n_wrap, started, counted;
    n_st = m_st; n_q = m_q; n_mod = m_mod; n_os = m_os; n_wrap = 0;
    started = 0; counted = 0;
    if (m_st != 1 && start) begin
      n_st = 1;
      n_mod = (mod_val == 0) ? (1 << W) : int'(mod_val);
      n_os = oneshot;
      started = 1;
    end else if (m_st == 1 && stop) begin
      n_st = 0;
    end else if (m_st == 1 && en) begin
      if (m_tc() && m_os) begin
        if (!load) n_st = 2;
      end else begin
        counted = 1;
      end
    end
    if (load) begin
      n_q = (int'(load_val) < n_mod) ? int'(load_val) : 0;
    end else if (started) begin
      n_q = up_dn ? 0 : n_mod - 1;
    end else if (counted) begin
      if (up_dn) begin
        n_q = (m_q + 1) % m_mod;
        n_wrap = (m_q == m_mod - 1);
      end else begin
        n_q = (m_q + m_mod - 1) % m_mod;
        n_wrap = (m_q == 0);
      end
    end
    m_st = n_st; m_q = n_q; m_mod = n_mod; m_os = n_os; m_wrap = n_wrap;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0, 0);

    //  st sp e  u  os ld mv  lv  q    tc wr bu dn
    add(1, 0, 1, 1, 0, 0, 5,  0,  0,   0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  1,   0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  2,   0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  3,   0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  4,   1, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  0,   0, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  1,   0, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0,  0,  1,   0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 3,  0,  2,   0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0,  0,  1,   0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0,  0,  0,   1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0,  0,  0,   0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0,  0,  0,   0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 3,  0,  2,   0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0,  0,  2,   0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 10, 0,  0,   0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1, 0,  7,  7,   0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 1, 0,  12, 0,   0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 1, 0,  9,  9,   1, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  0,   0, 1, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0,  0,  0,   0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0,  0,  255, 0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  0,   0, 1, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0,  0,  0,   0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1,  0,  0,   1, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  0,   1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  0,   1, 1, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0,  0,  0,   0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 6,  0,  0,   0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  1,   0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  2,   0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0,  0,  2,   0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0,  0,  2,   0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0,  0,  2,   0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0,  3,   0, 0, 1, 0);

    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_q", int'(q), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_tc", int'(tc), 0);
    chk("reset_wrap", int'(wrap), 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].st, vq[i].sp, vq[i].e, vq[i].u, vq[i].os, vq[i].ld,
            vq[i].mv, vq[i].lv);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_q", i), int'(q), vq[i].xq);
      chk($sformatf("v%0d_tc", i), int'(tc), int'(vq[i].xtc));
      chk($sformatf("v%0d_wrap", i), int'(wrap), int'(vq[i].xwrap));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(vq[i].xbusy));
      chk($sformatf("v%0d_done", i), int'(done), int'(vq[i].xdone));
    end

    // async reset mid-count at q=3, checked before the next edge
    #2 rst = 1'b1;
    #1;
    chk("arst_q", int'(q), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_wrap", int'(wrap), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 0, 1, 0, 0, 0, 4, 0);
    @(posedge clk);
    #1;
    chk("post_rst_q", int'(q), 3);
    chk("post_rst_busy", int'(busy), 1);

    // randomized traffic against the reference model
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    for (int n = 0; n < 4000; n++) begin
      int sel;
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 15) == 0);
      load    = ($urandom_range(0, 9) == 0);
      en      = ($urandom_range(0, 3) != 0);
      oneshot = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) up_dn = ~up_dn;
      sel = $urandom_range(0, 7);
      case (sel)
        0: mod_val = 8'd0;
        1: mod_val = 8'd1;
        2: mod_val = 8'd2;
        3: mod_val = 8'd4;
        4, 5: mod_val = 8'($urandom_range(2, 20));
        default: mod_val = 8'($urandom_range(0, 255));
      endcase
      load_val = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 24))
                                             : 8'($urandom_range(0, 255));
      #3;
      chk("rnd_tc", int'(tc), int'(m_tc()));
      m_step();
      @(posedge clk);
      #1;
      chk("rnd_q", int'(q), m_q);
      chk("rnd_wrap", int'(wrap), int'(m_wrap));
      chk("rnd_busy", int'(busy), int'(m_st == 1));
      chk("rnd_done", int'(done), int'(m_st == 2));
`ifdef MOD_N_GRAY_OUT_EN
      chk("rnd_gray", int'(q_gray), m_q ^ (m_q >> 1));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
